// File: rtl/pla_pkg.sv
// Shared constants and state encoding for the PLA evaluation engine.
package pla_pkg;

  localparam int N_IN_DEF   = 10;
  localparam int N_OUT_DEF  = 12;
  localparam int N_TERM_DEF = 64;
  localparam int P_DEF      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pla_term_match.sv
// One AND-plane product term: matches when enabled and every cared input bit
// equals its literal polarity.
module pla_term_match #(
  parameter int N_IN = 10
) (
  input  logic [N_IN-1:0] in_reg,
  input  logic [N_IN-1:0] mask,
  input  logic [N_IN-1:0] val,
  input  logic            en,
  output logic            match
);

  assign match = en && (((in_reg ^ val) & mask) == '0);

endmodule

// File: rtl/pla_eval_engine.sv
// Programmable PLA evaluator: sweeps the term table P entries per cycle and
// ORs the rows of matching terms, then presents the inverted-as-configured result.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | ready for input; config writes allowed when no input accept
//   EVAL  | sweeping term slices cnt*P .. cnt*P+P-1 into acc
//   DONE  | result registered, out_valid held until out_ready
module pla_eval_engine
  import pla_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int N_OUT  = N_OUT_DEF,
  parameter int N_TERM = N_TERM_DEF,
  parameter int P      = P_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [$clog2(N_TERM)-1:0] cfg_addr,
  input  logic                      cfg_sel_inv,
  input  logic [N_IN-1:0]           cfg_in_mask,
  input  logic [N_IN-1:0]           cfg_in_val,
  input  logic [N_OUT-1:0]          cfg_out,
  input  logic                      cfg_en,
  output logic                      cfg_ack,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N_IN-1:0]           in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N_OUT-1:0]          out_data
);

  localparam int AW     = $clog2(N_TERM);
  localparam int N_STEP = N_TERM / P;
  localparam int CNT_W  = (N_STEP > 1) ? $clog2(N_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_STEP - 1);

  if (N_TERM % P != 0) begin : g_bad_p
    $error("pla_eval_engine: N_TERM must be a multiple of P");
  end

  state_t             state, state_nxt;
  logic [N_IN-1:0]    in_reg;
  logic [N_OUT-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               out_valid_q;
  logic [N_OUT-1:0]   out_data_q;

  logic               tbl_en   [N_TERM];
  logic [N_IN-1:0]    tbl_mask [N_TERM];
  logic [N_IN-1:0]    tbl_val  [N_TERM];
  logic [N_OUT-1:0]   tbl_out  [N_TERM];
  logic [N_OUT-1:0]   out_inv;

  logic [AW-1:0]      term_idx [P];
  logic [P-1:0]       match;
  logic [N_OUT-1:0]   slice_or;

  // An input accept in IDLE takes priority over a coincident config write.
  assign in_ready  = (state == IDLE);
  assign cfg_ack   = !rst && (state == IDLE) && cfg_we && !in_valid;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_TERM; i++) begin
        tbl_en[i]   <= 1'b0;
        tbl_mask[i] <= '0;
        tbl_val[i]  <= '0;
        tbl_out[i]  <= '0;
      end
      out_inv <= '0;
    end else if (cfg_ack) begin
      if (cfg_sel_inv) begin
        out_inv <= cfg_out;
      end else begin
        tbl_en[cfg_addr]   <= cfg_en;
        tbl_mask[cfg_addr] <= cfg_in_mask;
        tbl_val[cfg_addr]  <= cfg_in_val;
        tbl_out[cfg_addr]  <= cfg_out;
      end
    end
  end

  for (genvar k = 0; k < P; k++) begin : g_term
    assign term_idx[k] = AW'(cnt) * AW'(P) + AW'(k);

    pla_term_match #(.N_IN(N_IN)) u_match (
      .in_reg (in_reg),
      .mask   (tbl_mask[term_idx[k]]),
      .val    (tbl_val[term_idx[k]]),
      .en     (tbl_en[term_idx[k]]),
      .match  (match[k])
    );
  end

  always_comb begin
    slice_or = '0;
    for (int k = 0; k < P; k++) begin
      if (match[k]) slice_or = slice_or | tbl_out[term_idx[k]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = EVAL;
      EVAL:    if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    if (out_valid_q && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The first DONE cycle registers the result, so out_valid appears one
  // cycle after the sweep ends and stays glitch-free while held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_reg      <= '0;
      acc         <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_reg <= in_data;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        EVAL: begin
          acc <= acc | slice_or;
          if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= acc ^ out_inv;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
